// File: rtl/xfer_arb_pkg.sv
// Shared encodings for the xfer_arbiter slice: FSM states, engine phase codes, defaults.
package xfer_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_GRANT = 3'd1,
        ST_WRITE = 3'd2,
        ST_READ  = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    localparam int unsigned PH_W = 2;
    localparam logic [PH_W-1:0] PH_IDLE  = 2'd0;
    localparam logic [PH_W-1:0] PH_WRITE = 2'd1;
    localparam logic [PH_W-1:0] PH_READ  = 2'd2;

    localparam int unsigned TIMEOUT_DEFAULT = 16;
    localparam int unsigned CNT_W           = 8;

endpackage

// File: rtl/xfer_arbiter_if.sv
// Requester/engine bundle of the xfer_arbiter; master is the arbiter side.
interface xfer_arbiter_if
    import xfer_arb_pkg::*;
#(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned ID_W  = 2
);
    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] grant;
    logic [ID_W-1:0]  grant_id;
    logic             busy;
    logic             eng_start;
    logic [PH_W-1:0]  eng_phase;
    logic             eng_done;
    logic             ack;
    logic             err;

    modport master (
        input  req, eng_done,
        output grant, grant_id, busy, eng_start, eng_phase, ack, err
    );

    modport slave (
        output req, eng_done,
        input  grant, grant_id, busy, eng_start, eng_phase, ack, err
    );
endinterface

// File: rtl/rr_picker.sv
// Combinational round-robin pick: first set request after last_i, wrapping at N_REQ.
module rr_picker #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned ID_W  = 2
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [ID_W-1:0]  last_i,
    output logic [N_REQ-1:0] win_o,
    output logic [ID_W-1:0]  win_id_o,
    output logic             valid_o
);
    localparam int unsigned SEL_W = $clog2(N_REQ);

    always_comb begin
        int unsigned idx;
        idx      = 0;
        win_o    = '0;
        win_id_o = '0;
        valid_o  = 1'b0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            idx = (32'(last_i) + k) % N_REQ;
            if (!valid_o && req_i[SEL_W'(idx)]) begin
                valid_o               = 1'b1;
                win_id_o              = ID_W'(idx);
                win_o[SEL_W'(idx)]    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/xfer_arbiter.sv
// Round-robin owner selection plus WRITE/READ sequencing of the shared engine.
// Optional phase timeout enabled by defining XFER_ARBITER_TIMEOUT_EN.
module xfer_arbiter
    import xfer_arb_pkg::*;
#(
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned ID_W    = 2,
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic           clk,
    input  logic           rst,
    xfer_arbiter_if.master bus
);
    state_e           state_q;
    logic [ID_W-1:0]  last_q;
    logic [N_REQ-1:0] owner_q;
    logic [ID_W-1:0]  owner_id_q;
    logic             busy_q;
    logic             eng_start_q;
    logic [PH_W-1:0]  eng_phase_q;
    logic             ack_q;
    logic             err_q;

    logic [N_REQ-1:0] pick_win;
    logic [ID_W-1:0]  pick_id;
    logic             pick_valid;
    logic             timeout_c;

    rr_picker #(.N_REQ(N_REQ), .ID_W(ID_W)) u_rr_picker (
        .req_i    (bus.req),
        .last_i   (last_q),
        .win_o    (pick_win),
        .win_id_o (pick_id),
        .valid_o  (pick_valid)
    );

`ifdef XFER_ARBITER_TIMEOUT_EN
    logic [CNT_W-1:0] cnt_q;

    // Cycles spent in the current phase; cleared on entry to WRITE and READ.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if ((state_q != ST_WRITE && state_q != ST_READ) ||
                     (state_q == ST_WRITE && bus.eng_done)) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign timeout_c = (cnt_q == CNT_W'(TIMEOUT - 1));
`else
    logic unused_timeout;
    assign unused_timeout = ^CNT_W'(TIMEOUT);
    assign timeout_c      = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            last_q      <= ID_W'(N_REQ - 1);
            owner_q     <= '0;
            owner_id_q  <= '0;
            busy_q      <= 1'b0;
            eng_start_q <= 1'b0;
            eng_phase_q <= PH_IDLE;
            ack_q       <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            eng_start_q <= 1'b0;
            ack_q       <= 1'b0;
            err_q       <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (pick_valid) begin
                        state_q     <= ST_GRANT;
                        owner_q     <= pick_win;
                        owner_id_q  <= pick_id;
                        busy_q      <= 1'b1;
                        eng_start_q <= 1'b1;
                    end
                end
                ST_GRANT: begin
                    state_q     <= ST_WRITE;
                    eng_phase_q <= PH_WRITE;
                end
                ST_WRITE: begin
                    if (bus.eng_done) begin
                        state_q     <= ST_READ;
                        eng_phase_q <= PH_READ;
                    end else if (timeout_c) begin
                        state_q     <= ST_DONE;
                        eng_phase_q <= PH_IDLE;
                        ack_q       <= 1'b1;
                        err_q       <= 1'b1;
                    end
                end
                ST_READ: begin
                    if (bus.eng_done || timeout_c) begin
                        state_q     <= ST_DONE;
                        eng_phase_q <= PH_IDLE;
                        ack_q       <= 1'b1;
                        err_q       <= !bus.eng_done;
                    end
                end
                ST_DONE: begin
                    state_q    <= ST_IDLE;
                    last_q     <= owner_id_q;
                    owner_q    <= '0;
                    owner_id_q <= '0;
                    busy_q     <= 1'b0;
                end
                default: begin
                    state_q     <= ST_IDLE;
                    owner_q     <= '0;
                    owner_id_q  <= '0;
                    busy_q      <= 1'b0;
                    eng_phase_q <= PH_IDLE;
                end
            endcase
        end
    end

    assign bus.grant     = owner_q;
    assign bus.grant_id  = owner_id_q;
    assign bus.busy      = busy_q;
    assign bus.eng_start = eng_start_q;
    assign bus.eng_phase = eng_phase_q;
    assign bus.ack       = ack_q;
    assign bus.err       = err_q;

endmodule

// File: tb/tb_xfer_arbiter.sv
// Directed bench for xfer_arbiter with hand-computed expectations; covers either macro build.
module tb_xfer_arbiter;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    xfer_arbiter_if #(.N_REQ(4), .ID_W(2)) bus ();

    xfer_arbiter #(.N_REQ(4), .ID_W(2), .TIMEOUT(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Full output snapshot against expected values.
    task automatic chk_out(input string tag, input logic [3:0] g, input logic [1:0] gid,
                           input logic bsy, input logic st, input logic [1:0] ph,
                           input logic ak, input logic er);
        check({tag, ".grant"},     32'(bus.grant),     32'(g));
        check({tag, ".grant_id"},  32'(bus.grant_id),  32'(gid));
        check({tag, ".busy"},      32'(bus.busy),      32'(bsy));
        check({tag, ".eng_start"}, 32'(bus.eng_start), 32'(st));
        check({tag, ".eng_phase"}, 32'(bus.eng_phase), 32'(ph));
        check({tag, ".ack"},       32'(bus.ack),       32'(ak));
        check({tag, ".err"},       32'(bus.err),       32'(er));
    endtask

    logic [3:0] exp_g;
    logic       err_seen;

    initial begin
        n_checks     = 0;
        n_errors     = 0;
        rst          = 1'b1;
        bus.req      = 4'b0000;
        bus.eng_done = 1'b0;
        step();
        step();
        chk_out("reset", 4'b0000, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
        rst = 1'b0;

        // Basic transaction, done after 3 cycles per phase.
        bus.req = 4'b0101;
        step();
        chk_out("t1.grant", 4'b0001, 2'd0, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0);
        step();
        chk_out("t1.w1", 4'b0001, 2'd0, 1'b1, 1'b0, 2'd1, 1'b0, 1'b0);
        step();
        chk_out("t1.w2", 4'b0001, 2'd0, 1'b1, 1'b0, 2'd1, 1'b0, 1'b0);
        step();
        chk_out("t1.w3", 4'b0001, 2'd0, 1'b1, 1'b0, 2'd1, 1'b0, 1'b0);
        bus.eng_done = 1'b1;
        step();
        bus.eng_done = 1'b0;
        chk_out("t1.r1", 4'b0001, 2'd0, 1'b1, 1'b0, 2'd2, 1'b0, 1'b0);
        step();
        step();
        chk_out("t1.r3", 4'b0001, 2'd0, 1'b1, 1'b0, 2'd2, 1'b0, 1'b0);
        bus.eng_done = 1'b1;
        step();
        bus.eng_done = 1'b0;
        chk_out("t1.done", 4'b0001, 2'd0, 1'b1, 1'b0, 2'd0, 1'b1, 1'b0);
        step();
        chk_out("t1.idle", 4'b0000, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
        // Still requesting 0101: round robin moves on to requester 2.
        step();
        chk_out("t1b.grant", 4'b0100, 2'd2, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0);
        bus.req      = 4'b0000;
        bus.eng_done = 1'b1;
        step();
        step();
        step();
        chk_out("t1b.done", 4'b0100, 2'd2, 1'b1, 1'b0, 2'd0, 1'b1, 1'b0);
        bus.eng_done = 1'b0;
        step();
        chk_out("t1b.idle", 4'b0000, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);

        // All requesting, done tied high: 0,1,2,3,0 with 5-cycle transactions.
        rst = 1'b1;
        step();
        chk_out("t2.rst", 4'b0000, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
        rst          = 1'b0;
        bus.req      = 4'b1111;
        bus.eng_done = 1'b1;
        for (int t = 0; t < 5; t++) begin
            exp_g = 4'b0001 << (t % 4);
            step();
            chk_out($sformatf("t2.%0d.grant", t), exp_g, 2'(t % 4), 1'b1, 1'b1, 2'd0, 1'b0, 1'b0);
            step();
            chk_out($sformatf("t2.%0d.write", t), exp_g, 2'(t % 4), 1'b1, 1'b0, 2'd1, 1'b0, 1'b0);
            step();
            chk_out($sformatf("t2.%0d.read", t), exp_g, 2'(t % 4), 1'b1, 1'b0, 2'd2, 1'b0, 1'b0);
            step();
            chk_out($sformatf("t2.%0d.done", t), exp_g, 2'(t % 4), 1'b1, 1'b0, 2'd0, 1'b1, 1'b0);
            step();
            chk_out($sformatf("t2.%0d.idle", t), 4'b0000, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
        end
        bus.req      = 4'b0000;
        bus.eng_done = 1'b0;

        // Reset in READ drops the transaction; priority returns to requester 0.
        bus.req = 4'b1000;
        step();
        chk_out("t3.grant", 4'b1000, 2'd3, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0);
        step();
        bus.eng_done = 1'b1;
        step();
        bus.eng_done = 1'b0;
        chk_out("t3.read", 4'b1000, 2'd3, 1'b1, 1'b0, 2'd2, 1'b0, 1'b0);
        rst = 1'b1;
        step();
        chk_out("t3.rst", 4'b0000, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
        rst     = 1'b0;
        bus.req = 4'b1111;
        step();
        chk_out("t3.regrant", 4'b0001, 2'd0, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0);
        bus.req      = 4'b0000;
        bus.eng_done = 1'b1;
        step();
        step();
        step();
        chk_out("t3.done", 4'b0001, 2'd0, 1'b1, 1'b0, 2'd0, 1'b1, 1'b0);
        bus.eng_done = 1'b0;
        step();

        // Owner withdraws request in WRITE; transaction still completes.
        bus.req = 4'b0100;
        step();
        chk_out("t4.grant", 4'b0100, 2'd2, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0);
        step();
        bus.req = 4'b0000;
        step();
        chk_out("t4.write", 4'b0100, 2'd2, 1'b1, 1'b0, 2'd1, 1'b0, 1'b0);
        bus.eng_done = 1'b1;
        step();
        chk_out("t4.read", 4'b0100, 2'd2, 1'b1, 1'b0, 2'd2, 1'b0, 1'b0);
        step();
        chk_out("t4.done", 4'b0100, 2'd2, 1'b1, 1'b0, 2'd0, 1'b1, 1'b0);
        bus.eng_done = 1'b0;
        step();
        chk_out("t4.idle", 4'b0000, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);

`ifdef XFER_ARBITER_TIMEOUT_EN
        // WRITE times out after 16 cycles with done low.
        bus.req = 4'b0001;
        step();
        chk_out("t5.grant", 4'b0001, 2'd0, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0);
        bus.req = 4'b0000;
        for (int c = 1; c <= 16; c++) begin
            step();
            chk_out($sformatf("t5.w%0d", c), 4'b0001, 2'd0, 1'b1, 1'b0, 2'd1, 1'b0, 1'b0);
        end
        step();
        chk_out("t5.timeout", 4'b0001, 2'd0, 1'b1, 1'b0, 2'd0, 1'b1, 1'b1);
        step();
        chk_out("t5.idle", 4'b0000, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);

        // Done in the 16th WRITE cycle beats the timeout.
        bus.req = 4'b0001;
        step();
        bus.req = 4'b0000;
        for (int c = 1; c <= 16; c++) begin
            step();
        end
        chk_out("t6.w16", 4'b0001, 2'd0, 1'b1, 1'b0, 2'd1, 1'b0, 1'b0);
        bus.eng_done = 1'b1;
        step();
        bus.eng_done = 1'b0;
        chk_out("t6.read", 4'b0001, 2'd0, 1'b1, 1'b0, 2'd2, 1'b0, 1'b0);
        bus.eng_done = 1'b1;
        step();
        bus.eng_done = 1'b0;
        chk_out("t6.done", 4'b0001, 2'd0, 1'b1, 1'b0, 2'd0, 1'b1, 1'b0);
        step();
`else
        // Without the timeout the engine may stall indefinitely in WRITE.
        bus.req = 4'b0001;
        step();
        chk_out("t5.grant", 4'b0001, 2'd0, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0);
        bus.req  = 4'b0000;
        err_seen = 1'b0;
        for (int c = 0; c < 300; c++) begin
            step();
            if (bus.err || bus.ack || bus.eng_phase != 2'd1) err_seen = 1'b1;
        end
        check("t5.stall_events", 32'(err_seen), 32'd0);
        chk_out("t5.w300", 4'b0001, 2'd0, 1'b1, 1'b0, 2'd1, 1'b0, 1'b0);
        bus.eng_done = 1'b1;
        step();
        step();
        chk_out("t5.done", 4'b0001, 2'd0, 1'b1, 1'b0, 2'd0, 1'b1, 1'b0);
        bus.eng_done = 1'b0;
        step();
`endif
        chk_out("end.idle", 4'b0000, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
